// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Rotates an active-low anode across DIGITS slots with a leading blank gap; content is double-buffered.
module seg7_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int CLK_DIV   = 12500,
  parameter int BLANK_CYC = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     mask_i,
  input  logic                  load_i,
  output logic                  pending_o,
  output logic                  frame_o,
  output logic [6:0]            hex_o,
  output logic [DIGITS-1:0]     an_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   pend_mask_q, pend_mask_d;
  logic                pend_vld_q, pend_vld_d;
  logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   disp_mask_q, disp_mask_d;

  logic                slot_end;
  logic                commit;
  logic [3:0]          sel_nib;
  logic                sel_en;
  logic                show;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  assign slot_end = (slot_cnt_q == CNT_LAST);
  assign commit   = slot_end && (idx_q == IDX_LAST);

  always_comb begin
    slot_cnt_d  = slot_end ? '0 : slot_cnt_q + 1'b1;
    idx_d       = idx_q;
    pend_data_d = pend_data_q;
    pend_mask_d = pend_mask_q;
    pend_vld_d  = pend_vld_q;
    disp_data_d = disp_data_q;
    disp_mask_d = disp_mask_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    // Commit uses the pre-edge pending contents; a coincident load refills pend afterwards.
    if (commit && pend_vld_q) begin
      disp_data_d = pend_data_q;
      disp_mask_d = pend_mask_q;
      pend_vld_d  = 1'b0;
    end
    if (load_i) begin
      pend_data_d = data_i;
      pend_mask_d = mask_i;
      pend_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_cnt_q  <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_mask_q <= '0;
      pend_vld_q  <= 1'b0;
      disp_data_q <= '0;
      disp_mask_q <= '0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_mask_q <= pend_mask_d;
      pend_vld_q  <= pend_vld_d;
      disp_data_q <= disp_data_d;
      disp_mask_q <= disp_mask_d;
    end
  end

  always_comb begin
    sel_nib = 4'h0;
    sel_en  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_nib = disp_data_q[4*k +: 4];
        sel_en  = disp_mask_q[k];
      end
    end
  end

  assign show      = (slot_cnt_q >= CNT_BLANK) && sel_en;
  assign hex_o     = show ? seg_decode(sel_nib) : 7'h7F;
  assign pending_o = pend_vld_q;
  assign frame_o   = commit;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
    assign an_o[gi] = ~(show && (idx_q == IDX_W'(gi)));
  end

endmodule
